// File: rtl/agu_burst.sv
// Burst address generator: emits count addresses stepping by a latched offset
// over a valid/ready handshake, then pulses a writeback address of base + count*offset.
module agu_burst #(
  parameter int ADDR_WIDTH  = 32,
  parameter int IMM_WIDTH   = 16,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_address,
  input  logic                   immediate_mode,
  input  logic [IMM_WIDTH-1:0]   immediate,
  input  logic [ADDR_WIDTH-1:0]  register_data,
  input  logic                   pre_index,
  input  logic [COUNT_WIDTH-1:0] count,
  output logic                   busy,
  output logic                   addr_valid,
  input  logic                   addr_ready,
  output logic [ADDR_WIDTH-1:0]  address,
  output logic                   last,
  output logic                   wb_valid,
  output logic [ADDR_WIDTH-1:0]  wb_address,
  output logic [1:0]             dbg_state
);

  // Handshake: a beat transfers on a rising edge where addr_valid && addr_ready.
  // While addr_valid is high and addr_ready low, address and last are held
  // stable, and addr_valid only drops after a transfer (or on reset).

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   last_q, last_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0]  offset_q, offset_d;
  logic [ADDR_WIDTH-1:0]  target_q, target_d;
  logic [ADDR_WIDTH-1:0]  wb_addr_q, wb_addr_d;

  logic [ADDR_WIDTH-1:0]  offset_in;
  logic [ADDR_WIDTH-1:0]  target_in;

  assign offset_in = immediate_mode ? ADDR_WIDTH'($signed(immediate)) : register_data;
  // Writeback value is independent of pre/post indexing, so compute it once at start.
  assign target_in = base_address + (ADDR_WIDTH'(count) * offset_in);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      last_q      <= 1'b0;
      remaining_q <= '0;
      offset_q    <= '0;
      target_q    <= '0;
      wb_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      remaining_q <= remaining_d;
      offset_q    <= offset_d;
      target_q    <= target_d;
      wb_addr_q   <= wb_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_d      = last_q;
    remaining_d = remaining_q;
    offset_d    = offset_q;
    target_d    = target_q;
    wb_addr_d   = wb_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          offset_d = offset_in;
          target_d = target_in;
          if (count == '0) begin
            state_d   = S_DONE;
            wb_addr_d = target_in;
          end else begin
            state_d     = S_RUN;
            addr_d      = pre_index ? (base_address + offset_in) : base_address;
            last_d      = (count == COUNT_WIDTH'(1));
            remaining_d = count;
          end
        end
      end
      S_RUN: begin
        if (addr_ready) begin
          if (last_q) begin
            state_d   = S_DONE;
            wb_addr_d = target_q;
          end else begin
            addr_d      = addr_q + offset_q;
            remaining_d = remaining_q - COUNT_WIDTH'(1);
            last_d      = (remaining_q == COUNT_WIDTH'(2));
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign addr_valid = (state_q == S_RUN);
  assign address    = addr_q;
  assign last       = last_q && (state_q == S_RUN);
  assign wb_valid   = (state_q == S_DONE);
  assign wb_address = wb_addr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_agu_burst.sv
// Directed bench for agu_burst: drivers push hand-computed beats and writeback
// addresses into queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_agu_burst;

  localparam int AW = 32;
  localparam int IW = 16;
  localparam int CW = 8;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_address;
  logic          immediate_mode;
  logic [IW-1:0] immediate;
  logic [AW-1:0] register_data;
  logic          pre_index;
  logic [CW-1:0] count;
  logic          busy;
  logic          addr_valid;
  logic          addr_ready;
  logic [AW-1:0] address;
  logic          last;
  logic          wb_valid;
  logic [AW-1:0] wb_address;
  logic [1:0]    dbg_state;

  logic [AW:0]   exp_q[$];
  logic [AW-1:0] exp_wb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  agu_burst #(.ADDR_WIDTH(AW), .IMM_WIDTH(IW), .COUNT_WIDTH(CW)) dut (
    .clock          (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_address   (base_address),
    .immediate_mode (immediate_mode),
    .immediate      (immediate),
    .register_data  (register_data),
    .pre_index      (pre_index),
    .count          (count),
    .busy           (busy),
    .addr_valid     (addr_valid),
    .addr_ready     (addr_ready),
    .address        (address),
    .last           (last),
    .wb_valid       (wb_valid),
    .wb_address     (wb_address),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (addr_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got address %h last %b, expected no beat", address, last);
        end else if (addr_ready) begin
          logic [AW:0] e;
          e = exp_q.pop_front();
          check("beat_addr", 64'(address), 64'(e[AW-1:0]));
          check("beat_last", 64'(last), 64'(e[AW]));
        end else begin
          check("hold_addr", 64'(address), 64'(exp_q[0][AW-1:0]));
        end
      end
      if (wb_valid) begin
        if (exp_wb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_wb: got wb_address %h, expected no wb_valid", wb_address);
        end else begin
          logic [AW-1:0] w;
          w = exp_wb_q.pop_front();
          check("wb_addr", 64'(wb_address), 64'(w));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_beat(input logic [AW-1:0] a, input logic l);
    exp_q.push_back({l, a});
  endtask

  task automatic scramble_inputs();
    base_address   = $urandom;
    immediate      = IW'($urandom_range(0, 65535));
    register_data  = $urandom;
    count          = CW'($urandom_range(0, 255));
    pre_index      = 1'($urandom_range(0, 1));
    immediate_mode = 1'($urandom_range(0, 1));
  endtask

  // Called at posedge+1; returns at posedge+1 right after start was sampled.
  task automatic start_burst(input logic [AW-1:0] b, input logic im, input logic [IW-1:0] imm,
                             input logic [AW-1:0] rd, input logic pre, input logic [CW-1:0] cnt,
                             input int stall);
    base_address   = b;
    immediate_mode = im;
    immediate      = imm;
    register_data  = rd;
    pre_index      = pre;
    count          = cnt;
    addr_ready     = (stall == 0);
    start          = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble_inputs();
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1;
      addr_ready = 1'b1;
    end
  endtask

  task automatic wait_wb(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (wb_valid) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no wb_valid, expected wb_valid within 64 cycles", name);
    end
    @(posedge clk);
    #1;
    check("busy_after_done", 64'(busy), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n        = 1'b0;
    start          = 1'b0;
    addr_ready     = 1'b1;
    base_address   = '0;
    immediate_mode = 1'b0;
    immediate      = '0;
    register_data  = '0;
    pre_index      = 1'b0;
    count          = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_valid", 64'(addr_valid), 64'(0));
    check("rst_wb_valid", 64'(wb_valid), 64'(0));
    check("rst_address", 64'(address), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // post-index immediate
    push_beat(32'h0000_1000, 1'b0);
    push_beat(32'h0000_1004, 1'b0);
    push_beat(32'h0000_1008, 1'b1);
    exp_wb_q.push_back(32'h0000_100C);
    start_burst(32'h0000_1000, 1'b1, 16'h0004, 32'h0, 1'b0, 8'd3, 0);
    check("busy_run", 64'(busy), 64'(1));
    wait_wb("post_imm");
    repeat (3) @(posedge clk);
    #1;
    check("wb_hold", 64'(wb_address), 64'h100C);

    // pre-index negative immediate
    push_beat(32'h0000_1FFC, 1'b0);
    push_beat(32'h0000_1FF8, 1'b1);
    exp_wb_q.push_back(32'h0000_1FF8);
    start_burst(32'h0000_2000, 1'b1, 16'hFFFC, 32'h0, 1'b1, 8'd2, 0);
    wait_wb("pre_neg");

    // register mode, 3 stall cycles on beat 0
    push_beat(32'h0000_0000, 1'b0);
    push_beat(32'h0000_0010, 1'b1);
    exp_wb_q.push_back(32'h0000_0020);
    start_burst(32'h0000_0000, 1'b0, 16'h7777, 32'h0000_0010, 1'b0, 8'd2, 3);
    wait_wb("reg_bp");

    // wrap-around
    push_beat(32'hFFFF_FFFC, 1'b0);
    push_beat(32'h0000_0000, 1'b1);
    exp_wb_q.push_back(32'h0000_0004);
    start_burst(32'hFFFF_FFFC, 1'b1, 16'h0004, 32'h0, 1'b0, 8'd2, 0);
    wait_wb("wrap");

    // zero count: no beats, wb equals base
    exp_wb_q.push_back(32'h0000_3000);
    start_burst(32'h0000_3000, 1'b1, 16'h0040, 32'h0, 1'b1, 8'd0, 0);
    wait_wb("zero_cnt");

    // start while busy is ignored
    push_beat(32'h0000_4000, 1'b0);
    push_beat(32'h0000_4008, 1'b0);
    push_beat(32'h0000_4010, 1'b1);
    exp_wb_q.push_back(32'h0000_4018);
    start_burst(32'h0000_4000, 1'b1, 16'h0008, 32'h0, 1'b0, 8'd3, 0);
    base_address   = 32'h0000_9000;
    immediate      = 16'h0100;
    count          = 8'd5;
    pre_index      = 1'b1;
    start          = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_wb("busy_start");
    repeat (3) @(posedge clk);
    #1;
    check("busy_start_idle", 64'(busy), 64'(0));

    // reset after the first beat of a 4-beat burst
    push_beat(32'h0000_5000, 1'b0);
    push_beat(32'h0000_5010, 1'b0);
    push_beat(32'h0000_5020, 1'b0);
    push_beat(32'h0000_5030, 1'b1);
    exp_wb_q.push_back(32'h0000_5040);
    start_burst(32'h0000_5000, 1'b1, 16'h0010, 32'h0, 1'b0, 8'd4, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(addr_valid), 64'(0));
    check("mid_rst_address", 64'(address), 64'(0));
    check("mid_rst_last", 64'(last), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_wb_valid", 64'(wb_valid), 64'(0));
    check("mid_rst_wb_address", 64'(wb_address), 64'(0));
    check("mid_rst_state", 64'(dbg_state), 64'(0));
    check("mid_rst_beats_left", 64'(exp_q.size()), 64'(3));
    exp_q.delete();
    exp_wb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // fresh burst after reset: register mode, pre-index, single beat
    push_beat(32'h0000_6100, 1'b1);
    exp_wb_q.push_back(32'h0000_6100);
    start_burst(32'h0000_6000, 1'b0, 16'h0001, 32'h0000_0100, 1'b1, 8'd1, 0);
    wait_wb("after_rst");

    repeat (5) @(posedge clk);
    #1;
    check("beat_queue_empty", 64'(exp_q.size()), 64'(0));
    check("wb_queue_empty", 64'(exp_wb_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
